// File: rtl/button_event_detect.sv
// Debounces the raw power/reset buttons in the standby clock domain and turns accepted
// level changes into one-cycle press/release pulses, debounced levels and a power long-press.
module button_event_detect #(
    parameter int unsigned DB_CYCLES   = 655,
    parameter int unsigned HOLD_CYCLES = 131072
) (
    input  logic       Clk32768,
    input  logic       ResetN,
    input  logic       PwrButtonN,
    input  logic       RstButtonN,
    output logic [3:0] Interrupt,
    output logic       PwrButtonLevel,
    output logic       RstButtonLevel,
    output logic       PwrLongPress
);

    localparam logic [9:0]  DbMax      = 10'(DB_CYCLES);
    localparam logic [17:0] HoldMax    = 18'(HOLD_CYCLES);
    localparam logic [17:0] HoldMaxM1  = 18'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } btnStateT;

    // Two-flop synchronisers; idle value is 1 (button released).
    logic pwrMetaQ, pwrSyncQ;
    logic rstMetaQ, rstSyncQ;

    always_ff @(posedge Clk32768) begin
        if (!ResetN) begin
            pwrMetaQ <= 1'b1;
            pwrSyncQ <= 1'b1;
            rstMetaQ <= 1'b1;
            rstSyncQ <= 1'b1;
        end else begin
            pwrMetaQ <= PwrButtonN;
            pwrSyncQ <= pwrMetaQ;
            rstMetaQ <= RstButtonN;
            rstSyncQ <= rstMetaQ;
        end
    end

    btnStateT   pwrStateQ, pwrStateD;
    logic [9:0] pwrDcntQ, pwrDcntD;
    logic       pwrPressD, pwrReleaseD;

    always_comb begin
        pwrStateD   = pwrStateQ;
        pwrDcntD    = pwrDcntQ;
        pwrPressD   = 1'b0;
        pwrReleaseD = 1'b0;
        unique case (pwrStateQ)
            StReleased: begin
                pwrDcntD = '0;
                if (!pwrSyncQ) begin
                    pwrStateD = StPressPend;
                    pwrDcntD  = 10'd1;
                end
            end
            StPressPend: begin
                if (pwrSyncQ) begin
                    pwrStateD = StReleased;
                    pwrDcntD  = '0;
                end else if (pwrDcntQ == DbMax) begin
                    pwrStateD = StPressed;
                    pwrDcntD  = '0;
                    pwrPressD = 1'b1;
                end else begin
                    pwrDcntD = pwrDcntQ + 10'd1;
                end
            end
            StPressed: begin
                pwrDcntD = '0;
                if (pwrSyncQ) begin
                    pwrStateD = StReleasePend;
                    pwrDcntD  = 10'd1;
                end
            end
            StReleasePend: begin
                if (!pwrSyncQ) begin
                    pwrStateD = StPressed;
                    pwrDcntD  = '0;
                end else if (pwrDcntQ == DbMax) begin
                    pwrStateD   = StReleased;
                    pwrDcntD    = '0;
                    pwrReleaseD = 1'b1;
                end else begin
                    pwrDcntD = pwrDcntQ + 10'd1;
                end
            end
        endcase
    end

    btnStateT   rstStateQ, rstStateD;
    logic [9:0] rstDcntQ, rstDcntD;
    logic       rstPressD, rstReleaseD;

    always_comb begin
        rstStateD   = rstStateQ;
        rstDcntD    = rstDcntQ;
        rstPressD   = 1'b0;
        rstReleaseD = 1'b0;
        unique case (rstStateQ)
            StReleased: begin
                rstDcntD = '0;
                if (!rstSyncQ) begin
                    rstStateD = StPressPend;
                    rstDcntD  = 10'd1;
                end
            end
            StPressPend: begin
                if (rstSyncQ) begin
                    rstStateD = StReleased;
                    rstDcntD  = '0;
                end else if (rstDcntQ == DbMax) begin
                    rstStateD = StPressed;
                    rstDcntD  = '0;
                    rstPressD = 1'b1;
                end else begin
                    rstDcntD = rstDcntQ + 10'd1;
                end
            end
            StPressed: begin
                rstDcntD = '0;
                if (rstSyncQ) begin
                    rstStateD = StReleasePend;
                    rstDcntD  = 10'd1;
                end
            end
            StReleasePend: begin
                if (!rstSyncQ) begin
                    rstStateD = StPressed;
                    rstDcntD  = '0;
                end else if (rstDcntQ == DbMax) begin
                    rstStateD   = StReleased;
                    rstDcntD    = '0;
                    rstReleaseD = 1'b1;
                end else begin
                    rstDcntD = rstDcntQ + 10'd1;
                end
            end
        endcase
    end

    // Hold timer runs off the registered state, so it starts the edge after the press pulse
    // and survives bounces inside RELEASE_PEND.
    logic        pwrHeld;
    logic [17:0] hcntQ, hcntD;
    logic        longPressD;

    assign pwrHeld = (pwrStateQ == StPressed) || (pwrStateQ == StReleasePend);

    always_comb begin
        hcntD      = '0;
        longPressD = 1'b0;
        if (pwrHeld) begin
            hcntD      = (hcntQ == HoldMax) ? hcntQ : hcntQ + 18'd1;
            longPressD = (hcntQ == HoldMaxM1);
        end
    end

    logic [3:0] interruptQ;
    logic       longPressQ;

    always_ff @(posedge Clk32768) begin
        if (!ResetN) begin
            pwrStateQ  <= StReleased;
            pwrDcntQ   <= '0;
            rstStateQ  <= StReleased;
            rstDcntQ   <= '0;
            hcntQ      <= '0;
            interruptQ <= '0;
            longPressQ <= 1'b0;
        end else begin
            pwrStateQ  <= pwrStateD;
            pwrDcntQ   <= pwrDcntD;
            rstStateQ  <= rstStateD;
            rstDcntQ   <= rstDcntD;
            hcntQ      <= hcntD;
            interruptQ <= {pwrPressD, pwrReleaseD, rstPressD, rstReleaseD};
            longPressQ <= longPressD;
        end
    end

    assign Interrupt      = interruptQ;
    assign PwrLongPress   = longPressQ;
    assign PwrButtonLevel = (pwrStateQ == StPressed) || (pwrStateQ == StReleasePend);
    assign RstButtonLevel = (rstStateQ == StPressed) || (rstStateQ == StReleasePend);

endmodule

// File: tb/tb_button_event_detect.sv
// Directed bench for button_event_detect with DB_CYCLES=4, HOLD_CYCLES=50.
// Observed vector is {Interrupt[3:0], PwrLongPress, PwrButtonLevel, RstButtonLevel}.
module tb_button_event_detect;

    logic       clk;
    logic       resetN;
    logic       pwrN;
    logic       rstN;
    logic [3:0] interrupt;
    logic       pwrLevel;
    logic       rstLevel;
    logic       longPress;
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    button_event_detect #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(50)
    ) dut (
        .Clk32768      (clk),
        .ResetN        (resetN),
        .PwrButtonN    (pwrN),
        .RstButtonN    (rstN),
        .Interrupt     (interrupt),
        .PwrButtonLevel(pwrLevel),
        .RstButtonLevel(rstLevel),
        .PwrLongPress  (longPress)
    );

    assign outs = {interrupt, longPress, pwrLevel, rstLevel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n edges; after each one the outputs must equal exp.
    task automatic run(input string tag, input int n, input logic [6:0] exp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(tag, outs, exp);
        end
    endtask

    initial begin
        resetN = 1'b0;
        pwrN   = 1'b0;
        rstN   = 1'b0;

        // Reset with both buttons held, then held through reset release.
        run("reset_hold", 5, 7'b0000_0_0_0);
        resetN = 1'b1;
        run("post_reset_wait", 6, 7'b0000_0_0_0);
        run("post_reset_press", 1, 7'b1010_0_1_1);
        run("post_reset_after", 1, 7'b0000_0_1_1);
        pwrN = 1'b1;
        rstN = 1'b1;
        run("both_rel_wait", 6, 7'b0000_0_1_1);
        run("both_rel_pulse", 1, 7'b0101_0_0_0);
        run("both_rel_after", 1, 7'b0000_0_0_0);

        // Clean power press, released 20 cycles later.
        pwrN = 1'b0;
        run("pwr_press_wait", 6, 7'b0000_0_0_0);
        run("pwr_press_pulse", 1, 7'b1000_0_1_0);
        run("pwr_held", 13, 7'b0000_0_1_0);
        pwrN = 1'b1;
        run("pwr_rel_wait", 6, 7'b0000_0_1_0);
        run("pwr_rel_pulse", 1, 7'b0100_0_0_0);
        run("pwr_rel_after", 1, 7'b0000_0_0_0);

        // Reset button: 4 low samples, 1 high, then steady low.
        rstN = 1'b0;
        run("rst_bounce_low", 4, 7'b0000_0_0_0);
        rstN = 1'b1;
        run("rst_bounce_high", 1, 7'b0000_0_0_0);
        rstN = 1'b0;
        run("rst_press_wait", 6, 7'b0000_0_0_0);
        run("rst_press_pulse", 1, 7'b0010_0_0_1);
        // One-sample high glitch while pressed.
        rstN = 1'b1;
        run("rst_glitch", 1, 7'b0000_0_0_1);
        rstN = 1'b0;
        run("rst_glitch_after", 10, 7'b0000_0_0_1);
        rstN = 1'b1;
        run("rst_rel_wait", 6, 7'b0000_0_0_1);
        run("rst_rel_pulse", 1, 7'b0001_0_0_0);
        run("rst_rel_after", 1, 7'b0000_0_0_0);

        // Long press: 200 cycles held, exactly one pulse 50 edges after the press pulse.
        pwrN = 1'b0;
        run("lp1_press_wait", 6, 7'b0000_0_0_0);
        run("lp1_press_pulse", 1, 7'b1000_0_1_0);
        run("lp1_hold", 49, 7'b0000_0_1_0);
        run("lp1_long", 1, 7'b0000_1_1_0);
        run("lp1_no_repeat", 143, 7'b0000_0_1_0);
        pwrN = 1'b1;
        run("lp1_rel_wait", 6, 7'b0000_0_1_0);
        run("lp1_rel_pulse", 1, 7'b0100_0_0_0);
        run("lp1_rel_after", 1, 7'b0000_0_0_0);
        pwrN = 1'b0;
        run("lp2_press_wait", 6, 7'b0000_0_0_0);
        run("lp2_press_pulse", 1, 7'b1000_0_1_0);
        run("lp2_hold", 49, 7'b0000_0_1_0);
        run("lp2_long", 1, 7'b0000_1_1_0);
        run("lp2_no_repeat", 5, 7'b0000_0_1_0);
        pwrN = 1'b1;
        run("lp2_rel_wait", 6, 7'b0000_0_1_0);
        run("lp2_rel_pulse", 1, 7'b0100_0_0_0);
        run("lp2_rel_after", 1, 7'b0000_0_0_0);

        // Simultaneous press, then reset in the middle of the release debounce.
        pwrN = 1'b0;
        rstN = 1'b0;
        run("sim_press_wait", 6, 7'b0000_0_0_0);
        run("sim_press_pulse", 1, 7'b1010_0_1_1);
        run("sim_press_after", 1, 7'b0000_0_1_1);
        pwrN = 1'b1;
        rstN = 1'b1;
        run("sim_rel_partial", 3, 7'b0000_0_1_1);
        resetN = 1'b0;
        run("mid_reset", 3, 7'b0000_0_0_0);
        resetN = 1'b1;
        run("after_mid_reset", 10, 7'b0000_0_0_0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
